// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream, writes 16-bit words, releases CPU on good checksum.
// Latency: one accepted byte per cycle; each word write adds a one-cycle WR bubble after its low byte.
// Backpressure: s_ready drops only during the WR bubble (and while rst is high).
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   s_valid, s_data, s_ready    : incoming byte stream (valid/ready handshake)
//   mem_wr, mem_waddr, mem_wdata: instruction-memory write port (outputs hold between writes)
//   cpu_rst, busy, done, err    : CPU reset control and load status
module imem_loader #(
    parameter int   AWIDTH      = 8,
    parameter logic CPU_RST_POL = 1'b0,
    parameter int   TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_waddr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CHK, DONE, ERR} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        hi_q, hi_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [AWIDTH-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              accept;
    logic              waiting;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            hi_q    <= '0;
            tmo_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            hi_q    <= hi_d;
            tmo_q   <= tmo_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Rst gates the handshake and status combinationally so a mid-frame reset
    // stops acceptance, writes and CPU release before the reset edge lands.
    assign s_ready   = !rst && (state_q != WR);
    assign accept    = s_valid && s_ready;
    assign mem_wr    = !rst && (state_q == WR);
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign busy      = !rst && (state_q inside {LEN, HI, LO, WR, CHK});
    assign done      = !rst && (state_q == DONE);
    assign err       = !rst && (state_q == ERR);
    assign cpu_rst   = (!rst && state_q == DONE) ? ~CPU_RST_POL : CPU_RST_POL;

    // States that wait on the stream; WR is excluded so its bubble is not idle time.
    assign waiting   = (state_q inside {LEN, HI, LO, CHK});

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        hi_d    = hi_q;
        tmo_d   = '0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (accept && s_data == 8'hA5) begin
                    state_d = LEN;
                    addr_d  = '0;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            LEN: begin
                if (accept) begin
                    if (s_data == 8'h00) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = s_data;
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (accept) begin
                    hi_d    = s_data;
                    csum_d  = csum_q ^ s_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (accept) begin
                    csum_d  = csum_q ^ s_data;
                    // Output registers load here so they stay stable outside WR.
                    waddr_d = addr_q;
                    wdata_d = {hi_q, s_data};
                    state_d = WR;
                end
            end
            WR: begin
                addr_d  = addr_q + AWIDTH'(1);
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? CHK : HI;
            end
            CHK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle-gap watchdog inside a frame; an accepted byte always restarts it.
        if (waiting && !accept) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = ERR;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end
endmodule
